// File: rtl/rv64g_pkg.sv
// rtl/rv64g_pkg.sv - shared widths and the issue-stage output payload type
package rv64g_pkg;

  localparam int NUM_REGS = 64;   // int + fp architectural registers
  localparam int XLEN     = 64;
  localparam int FUNC_W   = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);

  // Everything execute needs, captured in the issue slot in one register.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   rs3_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } issue_payload_t;

endpackage

// File: rtl/rv64g_hazard_check.sv
// rtl/rv64g_hazard_check.sv - combinational RAW/WAW check against the lock vector
// Ports: locks_i (lock vector), rs1/2/3_i + rs_used_i (sources), rd_i + rd_we_i
// (destination), wb_en_i/wb_addr_i (same-cycle unlock), fwd_o (per-source
// forward select, bit n = rs(n+1)), stall_o (any hazard).
module rv64g_hazard_check
  import rv64g_pkg::*;
#(
  parameter int NR = NUM_REGS,
  localparam int AW = $clog2(NR)
) (
  input  logic [NR-1:0] locks_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic [AW-1:0] rs3_i,
  input  logic [2:0]    rs_used_i,
  input  logic [AW-1:0] rd_i,
  input  logic          rd_we_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  output logic [2:0]    fwd_o,
  output logic          stall_o
);

  logic [AW-1:0] rs [3];
  logic [2:0]    src_haz;
  logic          dst_haz;

  assign rs[0] = rs1_i;
  assign rs[1] = rs2_i;
  assign rs[2] = rs3_i;

  always_comb begin
    fwd_o   = '0;
    src_haz = '0;
    for (int n = 0; n < 3; n++) begin
      fwd_o[n]   = wb_en_i && (wb_addr_i == rs[n]) && (rs[n] != '0);
      // x0 is never really locked, so a stray lock bit on it must not stall.
      src_haz[n] = rs_used_i[n] && (rs[n] != '0) && locks_i[rs[n]] && !fwd_o[n];
    end
    // A same-cycle unlock of rd clears the WAW: the register file lets the new
    // lock win over the unlock.
    dst_haz = rd_we_i && (rd_i != '0) && locks_i[rd_i] &&
              !(wb_en_i && (wb_addr_i == rd_i));
    stall_o = (|src_haz) || dst_haz;
  end

endmodule

// File: rtl/rv64g_issue_stage.sv
// rtl/rv64g_issue_stage.sv - single-entry issue stage between decode and execute
// Ports: pl_* decoded instruction in (valid/ready), locks_i + rsN_addr_o/rsN_data_i
// register-file lock vector and read ports, wr_lock_* lock request, wb_* observed
// writeback, ex_* registered output slot (valid/ready), stall_cnt_o hazard stalls.
module rv64g_issue_stage
  import rv64g_pkg::*;
#(
  parameter int NR = NUM_REGS,
  parameter int DW = XLEN,
  parameter int FW = FUNC_W,
  parameter int CW = 32,
  localparam int AW = $clog2(NR)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          pl_valid_i,
  output logic          pl_ready_o,
  input  logic [FW-1:0] pl_func_i,
  input  logic [AW-1:0] pl_rd_i,
  input  logic [AW-1:0] pl_rs1_i,
  input  logic [AW-1:0] pl_rs2_i,
  input  logic [AW-1:0] pl_rs3_i,
  input  logic [2:0]    pl_rs_used_i,
  input  logic          pl_rd_we_i,
  input  logic [DW-1:0] pl_imm_i,
  input  logic [DW-1:0] pl_pc_i,
  input  logic [NR-1:0] locks_i,
  output logic [AW-1:0] rs1_addr_o,
  output logic [AW-1:0] rs2_addr_o,
  output logic [AW-1:0] rs3_addr_o,
  input  logic [DW-1:0] rs1_data_i,
  input  logic [DW-1:0] rs2_data_i,
  input  logic [DW-1:0] rs3_data_i,
  output logic          wr_lock_en_o,
  output logic [AW-1:0] wr_lock_addr_o,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          ex_valid_o,
  input  logic          ex_ready_i,
  output logic [FW-1:0] ex_func_o,
  output logic [AW-1:0] ex_rd_o,
  output logic          ex_rd_we_o,
  output logic [DW-1:0] ex_rs1_data_o,
  output logic [DW-1:0] ex_rs2_data_o,
  output logic [DW-1:0] ex_rs3_data_o,
  output logic [DW-1:0] ex_imm_o,
  output logic [DW-1:0] ex_pc_o,
  output logic [CW-1:0] stall_cnt_o
);

  logic [2:0]     fwd;
  logic           hazard;
  logic           slot_free;
  logic           issue;
  logic [DW-1:0]  rf_data [3];
  logic [DW-1:0]  op_data [3];

  logic           ex_valid_q;
  issue_payload_t payload_d, payload_q;
  logic [CW-1:0]  stall_cnt_d, stall_cnt_q;

  rv64g_hazard_check #(.NR(NR)) u_hazard (
    .locks_i   (locks_i),
    .rs1_i     (pl_rs1_i),
    .rs2_i     (pl_rs2_i),
    .rs3_i     (pl_rs3_i),
    .rs_used_i (pl_rs_used_i),
    .rd_i      (pl_rd_i),
    .rd_we_i   (pl_rd_we_i),
    .wb_en_i   (wb_en_i),
    .wb_addr_i (wb_addr_i),
    .fwd_o     (fwd),
    .stall_o   (hazard)
  );

  assign rs1_addr_o = pl_rs1_i;
  assign rs2_addr_o = pl_rs2_i;
  assign rs3_addr_o = pl_rs3_i;

  assign slot_free  = ~ex_valid_q | ex_ready_i;
  assign pl_ready_o = slot_free & ~hazard;
  assign issue      = pl_valid_i & pl_ready_o;

  // The lock lands in locks_i next cycle, in time for a dependent follower.
  assign wr_lock_en_o   = issue & pl_rd_we_i & (pl_rd_i != '0);
  assign wr_lock_addr_o = pl_rd_i;

  assign rf_data[0] = rs1_data_i;
  assign rf_data[1] = rs2_data_i;
  assign rf_data[2] = rs3_data_i;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      if (!pl_rs_used_i[n])  op_data[n] = '0;
      else if (fwd[n])       op_data[n] = wb_data_i;
      else                   op_data[n] = rf_data[n];
    end
  end

  always_comb begin
    payload_d          = payload_q;
    payload_d.func     = pl_func_i;
    payload_d.rd       = pl_rd_i;
    payload_d.rd_we    = pl_rd_we_i;
    payload_d.rs1_data = op_data[0];
    payload_d.rs2_data = op_data[1];
    payload_d.rs3_data = op_data[2];
    payload_d.imm      = pl_imm_i;
    payload_d.pc       = pl_pc_i;
  end

  // Only hazard stalls are counted; backpressure (slot busy) is not.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pl_valid_i && slot_free && !pl_ready_o && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ex_valid_q  <= 1'b0;
      payload_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) begin
        ex_valid_q <= 1'b1;
        payload_q  <= payload_d;
      end else if (ex_ready_i) begin
        ex_valid_q <= 1'b0;
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_func_o     = payload_q.func;
  assign ex_rd_o       = payload_q.rd;
  assign ex_rd_we_o    = payload_q.rd_we;
  assign ex_rs1_data_o = payload_q.rs1_data;
  assign ex_rs2_data_o = payload_q.rs2_data;
  assign ex_rs3_data_o = payload_q.rs3_data;
  assign ex_imm_o      = payload_q.imm;
  assign ex_pc_o       = payload_q.pc;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
